decode_issue_stage: RTL and testbench

Parametrised RV32 decode/issue stage. It contains an internal register file, a per-register busy scoreboard for RAW/WAW hazard stalls, optional write-back bypass, valid/ready handshakes on both sides, and a one-entry registered output. It sits between the fetch-stage output and the execute stage, and receives write-back from the last pipeline stage.

---
 rtl/decode_issue_stage.sv | 217 +++++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_issue_stage
// Description : RV32 decode/issue stage with an internal register file, a
//               per-register busy scoreboard for RAW/WAW stalls, optional
//               write-back bypass, and a one-entry registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_stage #(
    parameter int NUM_REGS = 32,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic [31:0]         in_pc,
    input  logic                flush,
    input  logic                wb_en,
    input  logic [4:0]          wb_id,
    input  logic [31:0]         wb_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_instr,
    output logic [31:0]         out_pc,
    output logic [31:0]         out_rs1_data,
    output logic [31:0]         out_rs2_data,
    output logic [31:0]         out_imm,
    output logic [4:0]          out_rd,
    output logic                out_rd_we,
    output logic                out_illegal,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam logic [5:0] c_NREGS     = 6'(NUM_REGS);
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    logic [31:0]         r_rf [1:NUM_REGS-1];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_out_valid;
    logic [31:0]         r_out_instr, r_out_pc, r_out_rs1, r_out_rs2, r_out_imm;
    logic [4:0]          r_out_rd;
    logic                r_out_rd_we, r_out_illegal;

    logic [6:0]  w_op;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
    logic        w_known, w_writes, w_use1, w_use2;
    logic        w_illegal, w_rd_we, w_wb_ok, w_bypass_hit;
    logic        w_rs1_busy, w_rs2_busy, w_rd_busy, w_hazard;
    logic        w_in_ready, w_accept;
    logic [31:0] w_rs1_data, w_rs2_data;
    logic [NUM_REGS-1:0] w_busy_nxt;

    assign w_op    = in_instr[6:0];
    assign w_rd    = in_instr[11:7];
    assign w_rs1   = in_instr[19:15];
    assign w_rs2   = in_instr[24:20];
    assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u = {in_instr[31:12], 12'h000};
    assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                      in_instr[20], in_instr[30:21], 1'b0};

    // Opcode class decode: which register fields are used and immediate format
    always_comb begin
        w_known  = 1'b1;
        w_writes = 1'b0;
        w_use1   = 1'b0;
        w_use2   = 1'b0;
        w_imm    = '0;
        case (w_op)
            c_OP_REG: begin
                w_writes = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1;
            end
            c_OP_IMM, c_OP_LOAD, c_OP_JALR: begin
                w_writes = 1'b1; w_use1 = 1'b1; w_imm = w_imm_i;
            end
            c_OP_LUI, c_OP_AUIPC: begin
                w_writes = 1'b1; w_imm = w_imm_u;
            end
            c_OP_JAL: begin
                w_writes = 1'b1; w_imm = w_imm_j;
            end
            c_OP_STORE: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_imm = w_imm_s;
            end
            c_OP_BRANCH: begin
                w_use1 = 1'b1; w_use2 = 1'b1; w_imm = w_imm_b;
            end
            default: w_known = 1'b0;
        endcase
    end

    assign w_illegal = !w_known
                     || (w_use1   && ({1'b0, w_rs1} >= c_NREGS))
                     || (w_use2   && ({1'b0, w_rs2} >= c_NREGS))
                     || (w_writes && ({1'b0, w_rd}  >= c_NREGS));
    assign w_rd_we      = w_writes && (w_rd != 5'd0) && !w_illegal;
    assign w_wb_ok      = wb_en && (wb_id != 5'd0) && ({1'b0, wb_id} < c_NREGS);
    assign w_bypass_hit = BYPASS && w_wb_ok;

    // Register reads and busy lookups; x0 and out-of-range indices read as 0/not busy
    always_comb begin
        w_rs1_data = '0;
        w_rs2_data = '0;
        w_rs1_busy = 1'b0;
        w_rs2_busy = 1'b0;
        w_rd_busy  = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_rs1 == 5'(i)) begin
                w_rs1_data = (w_bypass_hit && (wb_id == w_rs1)) ? wb_data : r_rf[i];
                w_rs1_busy = r_busy[i] && !(w_bypass_hit && (wb_id == w_rs1));
            end
            if (w_rs2 == 5'(i)) begin
                w_rs2_data = (w_bypass_hit && (wb_id == w_rs2)) ? wb_data : r_rf[i];
                w_rs2_busy = r_busy[i] && !(w_bypass_hit && (wb_id == w_rs2));
            end
            if (w_rd == 5'(i)) begin
                w_rd_busy  = r_busy[i] && !(w_bypass_hit && (wb_id == w_rd));
            end
        end
    end

    // Illegal entries bypass the scoreboard entirely
    assign w_hazard   = !w_illegal && ((w_use1 && w_rs1_busy) || (w_use2 && w_rs2_busy)
                                       || (w_rd_we && w_rd_busy));
    assign w_in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_accept   = in_valid && w_in_ready;

    // Scoreboard next state: write-back and flush clear first, a new issue sets last
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (w_wb_ok && (wb_id == 5'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (flush && r_out_valid && r_out_rd_we && (r_out_rd == 5'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
            if (w_accept && w_rd_we && (w_rd == 5'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end
        end
    end

    // Register file write port and scoreboard state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wb_ok && (wb_id == 5'(i))) begin
                    r_rf[i] <= wb_data;
                end
            end
            r_busy <= w_busy_nxt;
        end
    end

    // One-entry output register: flush kills, accept replaces, consume drains
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_instr   <= '0;
            r_out_pc      <= '0;
            r_out_rs1     <= '0;
            r_out_rs2     <= '0;
            r_out_imm     <= '0;
            r_out_rd      <= '0;
            r_out_rd_we   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (flush) begin
            r_out_valid   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_instr   <= in_instr;
            r_out_pc      <= in_pc;
            r_out_rs1     <= w_rs1_data;
            r_out_rs2     <= w_rs2_data;
            r_out_imm     <= w_imm;
            r_out_rd      <= w_rd;
            r_out_rd_we   <= w_rd_we;
            r_out_illegal <= w_illegal;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_instr    = r_out_instr;
    assign out_pc       = r_out_pc;
    assign out_rs1_data = r_out_rs1;
    assign out_rs2_data = r_out_rs2;
    assign out_imm      = r_out_imm;
    assign out_rd       = r_out_rd;
    assign out_rd_we    = r_out_rd_we;
    assign out_illegal  = r_out_illegal;
    assign busy_vec     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_issue_stage
// Description : Drives three stage instances (RV32I+bypass, RV32I without
//               bypass, RV32E+bypass) and compares them every cycle against a
//               behavioural model; directed scenarios then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_stage;

    typedef struct packed {
        logic        v;
        logic [31:0] instr, pc, rs1, rs2, imm;
        logic [4:0]  rd;
        logic        we, ill;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0, wb_en = 1'b0, out_ready = 1'b0;
    logic [4:0]  wb_id = '0;
    logic [31:0] wb_data = '0;
    logic [2:0]        in_valid = '0;
    logic [2:0][31:0]  in_instr = '0;
    logic [2:0][31:0]  in_pc = '0;

    wire [2:0]         in_ready, out_valid, out_rd_we, out_illegal;
    wire [2:0][31:0]   out_instr, out_pc, out_rs1_data, out_rs2_data, out_imm, busy_w;
    wire [2:0][4:0]    out_rd;

    int ntot = 0, npass = 0, nfail = 0;

    // Behavioural model state per instance
    int          c_nr [3] = '{32, 32, 16};
    bit          c_bp [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m_rf   [3][32];
    logic [31:0] m_busy [3];
    ent_t        m_out  [3];
    ent_t        nx_out [3];
    bit          m_rdy [3], m_acc [3], m_wbok [3];

    // Fetch side: one pending instruction per instance
    bit          pend [3];
    logic [31:0] pins [3];
    logic [31:0] ppc  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NR = (g == 2) ? 16 : 32;
        localparam bit BP = (g == 1) ? 1'b0 : 1'b1;
        decode_issue_stage #(.NUM_REGS(NR), .BYPASS(BP)) u_dut (
            .clk(clk), .reset(reset),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_instr(in_instr[g]), .in_pc(in_pc[g]),
            .flush(flush), .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
            .out_valid(out_valid[g]), .out_ready(out_ready),
            .out_instr(out_instr[g]), .out_pc(out_pc[g]),
            .out_rs1_data(out_rs1_data[g]), .out_rs2_data(out_rs2_data[g]),
            .out_imm(out_imm[g]), .out_rd(out_rd[g]),
            .out_rd_we(out_rd_we[g]), .out_illegal(out_illegal[g]),
            .busy_vec(busy_w[g][NR-1:0])
        );
        if (NR < 32) begin : g_pad
            assign busy_w[g][31:NR] = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_addi(int rd, int rs1, int imm);
        logic [31:0] v;
        v = {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
        return v;
    endfunction

    function automatic logic [31:0] enc_add(int rd, int rs1, int rs2);
        logic [31:0] v;
        v = {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
        return v;
    endfunction

    function automatic logic [31:0] enc_lui(int rd, int imm20);
        logic [31:0] v;
        v = {20'(imm20), 5'(rd), 7'b0110111};
        return v;
    endfunction

    // A register is busy unless it is x0, out of range, or being freed by a bypassed write-back
    function automatic bit busy_ref(int k, logic [4:0] i, bit wbok);
        if (i == 5'd0 || int'(i) >= c_nr[k]) return 1'b0;
        if (c_bp[k] && wbok && wb_id == i) return 1'b0;
        return m_busy[k][i];
    endfunction

    function automatic logic [31:0] read_ref(int k, logic [4:0] i);
        if (i == 5'd0 || int'(i) >= c_nr[k]) return 32'h0;
        if (c_bp[k] && wb_en && wb_id == i) return wb_data;
        return m_rf[k][i];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 32; r++) m_rf[k][r] = 32'h0;
            m_busy[k] = 32'h0;
            m_out[k]  = '0;
        end
    endtask

    // Evaluate what instance k should do in the current cycle
    task automatic model_eval(input int k);
        logic [31:0] ins, imm;
        logic [4:0]  rd, r1, r2;
        bit          wr, u1, u2, kn, ill, we, haz;
        ins = in_instr[k];
        rd = ins[11:7]; r1 = ins[19:15]; r2 = ins[24:20];
        imm = 32'h0;
        {kn, wr, u1, u2} = 4'b0000;
        case (ins[6:0])
            7'b0110011: {kn, wr, u1, u2} = 4'b1111;
            7'b0010011, 7'b0000011, 7'b1100111: begin
                {kn, wr, u1, u2} = 4'b1110;
                imm = 32'($signed(ins[31:20]));
            end
            7'b0110111, 7'b0010111: begin
                {kn, wr, u1, u2} = 4'b1100;
                imm = ins & 32'hFFFF_F000;
            end
            7'b1101111: begin
                {kn, wr, u1, u2} = 4'b1100;
                imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'b0100011: begin
                {kn, wr, u1, u2} = 4'b1011;
                imm = 32'($signed({ins[31:25], ins[11:7]}));
            end
            7'b1100011: begin
                {kn, wr, u1, u2} = 4'b1011;
                imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            end
            default: kn = 1'b0;
        endcase
        ill = !kn || (u1 && int'(r1) >= c_nr[k]) || (u2 && int'(r2) >= c_nr[k])
              || (wr && int'(rd) >= c_nr[k]);
        we = wr && rd != 5'd0 && !ill;
        m_wbok[k] = wb_en && wb_id != 5'd0 && int'(wb_id) < c_nr[k];
        haz = !ill && ((u1 && busy_ref(k, r1, m_wbok[k])) || (u2 && busy_ref(k, r2, m_wbok[k]))
                       || (we && busy_ref(k, rd, m_wbok[k])));
        m_rdy[k] = (!m_out[k].v || out_ready) && !haz && !flush;
        m_acc[k] = in_valid[k] && m_rdy[k];
        nx_out[k] = '{v: 1'b1, instr: ins, pc: in_pc[k], rs1: read_ref(k, r1),
                      rs2: read_ref(k, r2), imm: imm, rd: rd, we: we, ill: ill};
    endtask

    task automatic model_commit(input int k);
        if (m_wbok[k]) begin
            m_rf[k][wb_id]   = wb_data;
            m_busy[k][wb_id] = 1'b0;
        end
        if (flush) begin
            if (m_out[k].v && m_out[k].we) m_busy[k][m_out[k].rd] = 1'b0;
            m_out[k].v = 1'b0;
        end else if (m_acc[k]) begin
            m_out[k] = nx_out[k];
            if (nx_out[k].we) m_busy[k][nx_out[k].rd] = 1'b1;
        end else if (out_ready) begin
            m_out[k].v = 1'b0;
        end
    endtask

    task automatic check_outputs(input int k);
        chk($sformatf("i%0d_out_valid", k), 32'(out_valid[k]), 32'(m_out[k].v));
        chk($sformatf("i%0d_out_instr", k), out_instr[k], m_out[k].instr);
        chk($sformatf("i%0d_out_pc", k), out_pc[k], m_out[k].pc);
        chk($sformatf("i%0d_out_rs1", k), out_rs1_data[k], m_out[k].rs1);
        chk($sformatf("i%0d_out_rs2", k), out_rs2_data[k], m_out[k].rs2);
        chk($sformatf("i%0d_out_imm", k), out_imm[k], m_out[k].imm);
        chk($sformatf("i%0d_out_rd", k), 32'(out_rd[k]), 32'(m_out[k].rd));
        chk($sformatf("i%0d_out_rd_we", k), 32'(out_rd_we[k]), 32'(m_out[k].we));
        chk($sformatf("i%0d_out_illegal", k), 32'(out_illegal[k]), 32'(m_out[k].ill));
        chk($sformatf("i%0d_busy_vec", k), busy_w[k], m_busy[k]);
    endtask

    // One clock cycle: drive, check in_ready mid-cycle, clock, check registered state
    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = pend[k];
            in_instr[k] = pend[k] ? pins[k] : 32'h0;
            in_pc[k]    = ppc[k];
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            model_eval(k);
            chk($sformatf("i%0d_in_ready", k), 32'(in_ready[k]), 32'(m_rdy[k]));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            model_commit(k);
            if (m_acc[k]) begin
                pend[k] = 1'b0;
                ppc[k]  = ppc[k] + 32'd4;
            end
            check_outputs(k);
        end
        wb_en = 1'b0;
        flush = 1'b0;
    endtask

    task automatic offer(input logic [31:0] ins);
        for (int k = 0; k < 3; k++) begin
            pend[k] = 1'b1;
            pins[k] = ins;
        end
    endtask

    task automatic do_wb(input int id, input logic [31:0] data);
        wb_en = 1'b1; wb_id = 5'(id); wb_data = data;
    endtask

    // Reset takes effect immediately (asynchronous), held across one edge
    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("i%0d_rst_out_valid", k), 32'(out_valid[k]), 32'h0);
            chk($sformatf("i%0d_rst_busy", k), busy_w[k], 32'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 12));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11];
        logic [31:0] v;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111,
                7'b1101111, 7'b0100011, 7'b1100011, 7'b1111111, 7'b0001011};
        v = $urandom;
        v[6:0]   = ops[$urandom_range(0, 10)];
        v[11:7]  = rand_reg();
        v[19:15] = rand_reg();
        v[24:20] = rand_reg();
        return v;
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            pend[k] = 1'b0; pins[k] = 32'h0; ppc[k] = 32'h1000;
        end
        do_reset();
        out_ready = 1'b1;

        // Back-to-back independent issues
        offer(enc_addi(1, 0, 5)); tick();
        chk("t1_imm5", out_imm[0], 32'd5);
        offer(enc_addi(2, 0, 7)); tick();
        chk("t1_imm7", out_imm[0], 32'd7);
        chk("t1_busy12", 32'(busy_w[0][2:1]), 32'h3);
        do_wb(1, 32'd5); tick();
        do_wb(2, 32'd7); tick();

        // RAW stall released by write-back of x3
        offer(enc_addi(3, 0, 1)); tick();
        offer(enc_add(4, 3, 3)); tick(); tick();
        chk("t2_stall_drained", 32'(out_valid[0]), 32'h0);
        do_wb(3, 32'd1); tick();
        chk("t2_byp_valid", 32'(out_valid[0]), 32'h1);
        chk("t2_byp_rs1", out_rs1_data[0], 32'd1);
        chk("t2_byp_rs2", out_rs2_data[0], 32'd1);
        chk("t2_nobyp_wait", 32'(out_valid[1]), 32'h0);
        tick();
        chk("t2_nobyp_valid", 32'(out_valid[1]), 32'h1);
        chk("t2_nobyp_rs1", out_rs1_data[1], 32'd1);
        do_wb(4, 32'd2); tick();

        // Backpressure holds the entry
        out_ready = 1'b0;
        offer(enc_addi(8, 0, 9)); tick();
        offer(enc_addi(9, 0, 3));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t3_hold_imm", out_imm[0], 32'd9);
        end
        out_ready = 1'b1; tick();
        chk("t3_release_imm", out_imm[0], 32'd3);

        // Flush kills the entry and its busy bit
        offer(enc_lui(5, 32'h12345)); tick();
        chk("t4_lui_imm", out_imm[0], 32'h1234_5000);
        flush = 1'b1; tick();
        chk("t4_flush_valid", 32'(out_valid[0]), 32'h0);
        chk("t4_flush_busy5", 32'(busy_w[0][5]), 32'h0);
        offer(enc_add(6, 5, 0)); tick();
        chk("t4_no_stall", 32'(out_valid[0]), 32'h1);
        chk("t4_rd6", 32'(out_rd[0]), 32'd6);

        // Illegal opcode and out-of-range index on RV32E
        offer(32'h0000_007F); tick();
        chk("t5_illegal_op", 32'(out_illegal[0]), 32'h1);
        chk("t5_illegal_op_we", 32'(out_rd_we[0]), 32'h0);
        offer(enc_add(20, 1, 2)); tick();
        chk("t5_rv32e_illegal", 32'(out_illegal[2]), 32'h1);
        chk("t5_rv32e_we", 32'(out_rd_we[2]), 32'h0);
        chk("t5_rv32e_busy", busy_w[2], 32'h0000_0340);
        chk("t5_rv32i_legal", 32'(out_illegal[0]), 32'h0);

        // Reset while an instruction is stalled on x7
        offer(enc_addi(7, 0, 3)); tick();
        offer(enc_add(10, 7, 7)); tick();
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t6_i%0d_x7_zero", k), out_rs1_data[k], 32'h0);
        end

        // Random traffic against the model, with one reset in the middle
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1) do_wb(int'(rand_reg()), $urandom);
            for (int k = 0; k < 3; k++) begin
                if (!pend[k] && $urandom_range(0, 3) != 0) begin
                    pend[k] = 1'b1;
                    pins[k] = rand_instr();
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
